// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the fetch/data Avalon-MM arbiter.
package mips_bus_pkg;

   typedef enum logic [1:0] {IDLE, BUS, RESP} arb_state_t;
   typedef enum logic {GNT_FETCH, GNT_DATA} grant_t;

   localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;
   localparam logic [3:0]  FETCH_BE      = 4'hF;

endpackage

// File: rtl/avalon_bus_arbiter_if.sv
// Core-side request/ack signals plus the shared Avalon-MM master port.
// master: the arbiter's view; slave: the core and Avalon fabric driving it.
interface avalon_bus_arbiter_if;
   logic        f_req;
   logic [31:0] f_addr;
   logic        f_ack;
   logic [31:0] f_rdata;
   logic        d_read;
   logic        d_write;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [3:0]  d_be;
   logic        d_ack;
   logic [31:0] d_rdata;
   logic [31:0] av_address;
   logic        av_read;
   logic        av_write;
   logic [31:0] av_writedata;
   logic [3:0]  av_byteenable;
   logic        av_waitrequest;
   logic [31:0] av_readdata;
   logic        bus_error;

   modport master (
      input  f_req, f_addr, d_read, d_write, d_addr, d_wdata, d_be, av_waitrequest, av_readdata,
      output f_ack, f_rdata, d_ack, d_rdata, av_address, av_read, av_write, av_writedata,
             av_byteenable, bus_error
   );

   modport slave (
      output f_req, f_addr, d_read, d_write, d_addr, d_wdata, d_be, av_waitrequest, av_readdata,
      input  f_ack, f_rdata, d_ack, d_rdata, av_address, av_read, av_write, av_writedata,
             av_byteenable, bus_error
   );
endinterface

// File: rtl/bus_watchdog.sv
// Counts waitrequest-stalled bus cycles; expire_o fires on the cycle the limit is reached.
module bus_watchdog #(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic clk,
   input  logic reset,
   input  logic clr_i,
   input  logic inc_i,
   output logic expire_o
);
   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i) begin
         cnt_d = cnt_q + CntW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire_o = inc_i && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/avalon_bus_arbiter.sv
// Serialises fetch and data requests onto one registered Avalon-MM master port.
// Define ARB_TIMEOUT_EN to abort transfers stalled by waitrequest and flag bus_error.
module avalon_bus_arbiter
   import mips_bus_pkg::*;
#(
   parameter int unsigned MAX_DATA_RUN = 4
`ifdef ARB_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT_CYCLES = 1024
`endif
) (
   input logic                  clk,
   input logic                  reset,
   avalon_bus_arbiter_if.master bus
);
   localparam int unsigned     RunW   = $clog2(MAX_DATA_RUN + 1);
   localparam logic [RunW-1:0] RunMax = RunW'(MAX_DATA_RUN);

   arb_state_t      state_q, state_d;
   grant_t          gnt_q, gnt_d;
   logic [RunW-1:0] run_q, run_d;
   logic [31:0]     addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
   logic [3:0]      be_q, be_d;
   logic            read_q, read_d, write_q, write_d;
   logic            f_ack_q, f_ack_d, d_ack_q, d_ack_d;
   logic            d_pend, abort;

   assign d_pend = bus.d_read | bus.d_write;

`ifdef ARB_TIMEOUT_EN
   logic err_q;

   bus_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk     (clk),
      .reset   (reset),
      .clr_i   ((state_q == IDLE) && (state_d == BUS)),
      .inc_i   ((state_q == BUS) && bus.av_waitrequest),
      .expire_o(abort)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         err_q <= 1'b0;
      end else if (abort) begin
         err_q <= 1'b1;
      end
   end

   assign bus.bus_error = err_q;
`else
   assign abort         = 1'b0;
   assign bus.bus_error = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      run_d   = run_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      read_d  = read_q;
      write_d = write_q;
      rdata_d = rdata_q;
      f_ack_d = 1'b0;
      d_ack_d = 1'b0;
      case (state_q)
         IDLE: begin
            // Data wins unless it has already starved a waiting fetch for RunMax grants.
            if (d_pend && (!bus.f_req || run_q < RunMax)) begin
               state_d = BUS;
               gnt_d   = GNT_DATA;
               if (bus.f_req) run_d = run_q + RunW'(1);
               addr_d  = bus.d_addr;
               wdata_d = bus.d_wdata;
               be_d    = bus.d_be;
               write_d = bus.d_write;
               read_d  = ~bus.d_write;
            end else if (bus.f_req) begin
               state_d = BUS;
               gnt_d   = GNT_FETCH;
               run_d   = '0;
               addr_d  = bus.f_addr;
               wdata_d = '0;
               be_d    = FETCH_BE;
               write_d = 1'b0;
               read_d  = 1'b1;
            end
         end
         BUS: begin
            if (!bus.av_waitrequest || abort) begin
               state_d = RESP;
               read_d  = 1'b0;
               write_d = 1'b0;
               f_ack_d = (gnt_q == GNT_FETCH);
               d_ack_d = (gnt_q == GNT_DATA);
               if (abort) begin
                  rdata_d = TIMEOUT_RDATA;
               end else if (read_q) begin
                  rdata_d = bus.av_readdata;
               end
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         gnt_q   <= GNT_FETCH;
         run_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         read_q  <= 1'b0;
         write_q <= 1'b0;
         rdata_q <= '0;
         f_ack_q <= 1'b0;
         d_ack_q <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         run_q   <= run_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         read_q  <= read_d;
         write_q <= write_d;
         rdata_q <= rdata_d;
         f_ack_q <= f_ack_d;
         d_ack_q <= d_ack_d;
      end
   end

   assign bus.av_address    = addr_q;
   assign bus.av_read       = read_q;
   assign bus.av_write      = write_q;
   assign bus.av_writedata  = wdata_q;
   assign bus.av_byteenable = be_q;
   assign bus.f_ack         = f_ack_q;
   assign bus.d_ack         = d_ack_q;
   assign bus.f_rdata       = rdata_q;
   assign bus.d_rdata       = rdata_q;
endmodule

// File: tb/tb_avalon_bus_arbiter.sv
// Directed bench for avalon_bus_arbiter: table of single transfers plus arbitration,
// reset and (with ARB_TIMEOUT_EN) timeout sequences.
module tb_avalon_bus_arbiter;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   slave_waits = 0;
   int   wait_left = 0;

   always #5 clk = ~clk;

   avalon_bus_arbiter_if bus ();

`ifdef ARB_TIMEOUT_EN
   avalon_bus_arbiter #(.MAX_DATA_RUN(4), .TIMEOUT_CYCLES(8)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );
`else
   avalon_bus_arbiter #(.MAX_DATA_RUN(4)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );
`endif

   // Avalon slave: stalls each transfer for slave_waits cycles.
   always @(negedge clk) begin
      if (bus.av_read || bus.av_write) begin
         bus.av_waitrequest = (wait_left != 0);
         if (wait_left != 0) wait_left = wait_left - 1;
      end else begin
         bus.av_waitrequest = 1'b0;
         wait_left = slave_waits;
      end
   end

   typedef struct {
      logic        f, rd, wr;
      logic [31:0] addr, wdata;
      logic [3:0]  be;
      int          waits;
      logic [31:0] rdata;
      logic [31:0] exp_addr, exp_wdata;
      logic [3:0]  exp_be;
      logic        exp_wr;
      int          exp_hi;
      logic        chk_rdata;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs[5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic drop_reqs();
      bus.f_req   = 1'b0;
      bus.d_read  = 1'b0;
      bus.d_write = 1'b0;
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int          hi = 0, bad = 0, own = 0, other = 0, both = 0;
      logic [31:0] got = '0;
      bit          done = 1'b0;
      slave_waits     = v.waits;
      bus.av_readdata = v.rdata;
      bus.f_addr      = v.f ? v.addr : 32'h5555_5555;
      bus.d_addr      = v.f ? 32'h5555_5555 : v.addr;
      bus.d_wdata     = v.wdata;
      bus.d_be        = v.be;
      bus.f_req       = v.f;
      bus.d_read      = v.rd;
      bus.d_write     = v.wr;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         if (bus.av_read || bus.av_write) begin
            hi++;
            if (bus.av_address !== v.exp_addr || bus.av_writedata !== v.exp_wdata ||
                bus.av_byteenable !== v.exp_be || bus.av_write !== v.exp_wr ||
                bus.av_read !== ~v.exp_wr) bad++;
         end
         if (bus.f_ack && bus.d_ack) both++;
         if (v.f ? bus.d_ack : bus.f_ack) other++;
         if (v.f ? bus.f_ack : bus.d_ack) begin
            own++;
            got  = v.f ? bus.f_rdata : bus.d_rdata;
            done = 1'b1;
            drop_reqs();
         end
      end
      @(negedge clk);
      check($sformatf("vec%0d_ack_pulse", idx), 32'(bus.f_ack | bus.d_ack), 32'd0);
      check($sformatf("vec%0d_bus_cycles", idx), hi, v.exp_hi);
      check($sformatf("vec%0d_bus_values", idx), bad, 0);
      check($sformatf("vec%0d_own_ack", idx), own, 1);
      check($sformatf("vec%0d_other_ack", idx), other + both, 0);
      if (v.chk_rdata) check($sformatf("vec%0d_rdata", idx), got, v.exp_rdata);
   endtask

   task automatic do_reset();
      drop_reqs();
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      int          n_acks, overlap, first_d;
      logic [31:0] got;
      logic [9:0]  order, exp_order;
      drop_reqs();
      bus.f_addr = '0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_be = '0;
      bus.av_readdata = '0; bus.av_waitrequest = 1'b0;

      // fields: f rd wr addr wdata be waits rdata | exp_addr exp_wdata exp_be exp_wr hi chk rdata
      vecs[0] = '{1, 0, 0, 32'hBFC0_0000, 32'h0, 4'h0, 2, 32'h2402_0005,
                  32'hBFC0_0000, 32'h0, 4'hF, 0, 3, 1, 32'h2402_0005};
      vecs[1] = '{0, 0, 1, 32'h0000_1004, 32'hCAFE_F00D, 4'b0011, 0, 32'h0,
                  32'h0000_1004, 32'hCAFE_F00D, 4'b0011, 1, 1, 0, 32'h0};
      vecs[2] = '{0, 1, 0, 32'h0000_2000, 32'h1111_2222, 4'hF, 1, 32'h1234_5678,
                  32'h0000_2000, 32'h1111_2222, 4'hF, 0, 2, 1, 32'h1234_5678};
      vecs[3] = '{0, 1, 1, 32'h0000_3008, 32'h0BAD_F00D, 4'hC, 3, 32'h0,
                  32'h0000_3008, 32'h0BAD_F00D, 4'hC, 1, 4, 0, 32'h0};
      vecs[4] = '{1, 0, 0, 32'hBFC0_0004, 32'hFFFF_FFFF, 4'h5, 0, 32'h8C42_0000,
                  32'hBFC0_0004, 32'h0, 4'hF, 0, 1, 1, 32'h8C42_0000};

      repeat (2) @(negedge clk);
      check("rst_ctrl", 32'({bus.av_read, bus.av_write, bus.f_ack, bus.d_ack, bus.bus_error}), 0);
      check("rst_addr", bus.av_address, 32'h0);
      check("rst_rdata", bus.f_rdata, 32'h0);
      check("rst_be", 32'(bus.av_byteenable), 0);
      reset = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

      // Simultaneous fetch and data read: data first, acks never overlap.
      slave_waits = 0;
      bus.av_readdata = 32'hA5A5_0001;
      bus.f_addr = 32'hBFC0_0010; bus.d_addr = 32'h0000_0040; bus.d_be = 4'hF;
      bus.f_req = 1'b1; bus.d_read = 1'b1;
      n_acks = 0; overlap = 0; first_d = -1; got = '0;
      for (int c = 0; c < 40 && n_acks < 2; c++) begin
         @(negedge clk);
         if (bus.f_ack && bus.d_ack) overlap++;
         if (bus.d_ack) begin
            n_acks++; bus.d_read = 1'b0;
            if (first_d < 0) first_d = 1;
         end
         if (bus.f_ack) begin
            n_acks++; bus.f_req = 1'b0; got = bus.f_rdata;
            if (first_d < 0) first_d = 0;
         end
      end
      check("pair_acks", n_acks, 2);
      check("pair_data_first", first_d, 1);
      check("pair_overlap", overlap, 0);
      check("pair_f_rdata", got, 32'hA5A5_0001);

      // Continuous contention: four data grants then one fetch, repeating.
      do_reset();
      bus.f_req = 1'b1; bus.d_write = 1'b1; bus.d_wdata = 32'h7777_0000;
      n_acks = 0; overlap = 0; order = '0;
      exp_order = 10'b01111_01111;
      for (int c = 0; c < 200 && n_acks < 10; c++) begin
         @(negedge clk);
         if (bus.f_ack && bus.d_ack) overlap++;
         else if (bus.f_ack || bus.d_ack) begin
            order[n_acks] = bus.d_ack;
            n_acks++;
         end
      end
      drop_reqs();
      check("run_ack_count", n_acks, 10);
      check("run_order", 32'(order), 32'(exp_order));
      check("run_overlap", overlap, 0);
      repeat (3) @(negedge clk);

      // Reset mid-transfer with waitrequest stuck high.
      slave_waits = 1000;
      bus.f_addr = 32'hBFC0_0020; bus.f_req = 1'b1;
      repeat (4) @(negedge clk);
      check("mid_busy", 32'(bus.av_read), 1);
      reset = 1'b0;
      @(negedge clk);
      check("mid_rst_av", 32'({bus.av_read, bus.av_write}), 0);
      check("mid_rst_ack", 32'({bus.f_ack, bus.d_ack}), 0);
      drop_reqs();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check("mid_idle", 32'({bus.av_read, bus.av_write, bus.f_ack, bus.d_ack}), 0);
      slave_waits = 0;
      @(negedge clk);
      run_vec(5, vecs[0]);

`ifdef ARB_TIMEOUT_EN
      begin
         int hi = 0;
         bit done = 1'b0;
         do_reset();
         slave_waits = 1000;
         bus.d_addr = 32'h0000_4000; bus.d_read = 1'b1;
         got = '0;
         for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (bus.av_read) hi++;
            if (bus.d_ack) begin
               got = bus.d_rdata; done = 1'b1; drop_reqs();
            end
         end
         check("to_wait_cycles", hi, 8);
         check("to_rdata", got, 32'hDEAD_BEEF);
         repeat (5) @(negedge clk);
         check("to_sticky", 32'(bus.bus_error), 1);
         slave_waits = 0;
         do_reset();
         check("to_cleared", 32'(bus.bus_error), 0);
      end
`else
      check("no_bus_error", 32'(bus.bus_error), 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
